// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared FSM type and XNOR LFSR helper functions for the noise generator
package lfsr_pkg;
  typedef enum logic {WARM, RUN} fsm_e;
  // Returns {next_state, fb}; state and mask are zero-extended to 64 bits, w is the live width
  function automatic logic [64:0] lfsr_step(input logic [63:0] s, input logic [63:0] mask, input int unsigned w);
    logic [63:0] m;
    logic fb;
    m = (w >= 64) ? '1 : (64'd1 << w) - 64'd1;
    fb = ~^(s & mask);
    return {((s << 1) | 64'(fb)) & m, fb};
  endfunction
  function automatic int unsigned popcount(input logic [63:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < 64; i++) c += 32'(v[i]);
    return c;
  endfunction
endpackage

// File: rtl/lfsr_leap.sv
// lfsr_leap: combinational OUT_BITS-deep unrolled XNOR LFSR stepper
module lfsr_leap import lfsr_pkg::*; #(
  parameter int WIDTH = 15,
  parameter logic [WIDTH-1:0] TAP_MASK = WIDTH'(15'h6000),
  parameter int OUT_BITS = 2
) (
  input  logic [WIDTH-1:0]    state,
  output logic [WIDTH-1:0]    next,
  output logic [OUT_BITS-1:0] bits
);
  logic [63:0] s;
  logic [64:0] r;
  always_comb begin
    s = 64'(state);
    r = '0;
    bits = '0;
    for (int k = 0; k < OUT_BITS; k++) begin
      r = lfsr_step(s, 64'(TAP_MASK), WIDTH);
      bits[k] = r[0];
      s = r[64:1];
    end
    next = s[WIDTH-1:0];
  end
endmodule

// File: rtl/lfsr_noise_gen.sv
// lfsr_noise_gen: leap-forward XNOR LFSR noise source with seed load, warm-up discard
// and lock-up recovery; dout_sum is a binomial sample of the OUT_BITS fresh bits.
module lfsr_noise_gen import lfsr_pkg::*; #(
  parameter int WIDTH = 15,
  parameter logic [WIDTH-1:0] TAP_MASK = WIDTH'(15'h6000),
  parameter logic [WIDTH-1:0] INIT = WIDTH'(1),
  parameter int OUT_BITS = 2,
  parameter int WARMUP = 16,
  parameter int SUM_W = $clog2(OUT_BITS + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                seed_valid,
  input  logic [WIDTH-1:0]    seed,
  output logic                seed_ready,
  output logic [OUT_BITS-1:0] dout,
  output logic [SUM_W-1:0]    dout_sum,
  output logic                out_valid,
  output logic [WIDTH-1:0]    state_q,
  output logic                lock_err
);
  localparam int WCW = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam fsm_e FSM0 = (WARMUP == 0) ? RUN : WARM;
  fsm_e fsm;
  logic [WCW-1:0] wcnt;
  logic [WIDTH-1:0] nxt;
  logic [OUT_BITS-1:0] bits;
  logic load, seed_bad, locked;
  assign load = seed_valid && seed_ready;
  assign seed_bad = &seed;
  assign locked = &state_q;
  lfsr_leap #(.WIDTH(WIDTH), .TAP_MASK(TAP_MASK), .OUT_BITS(OUT_BITS)) u_leap (
    .state(state_q),
    .next (nxt),
    .bits (bits)
  );
  // All-ones is the XNOR lock-up state: a bad seed or an upset both fall back to INIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      dout <= '0;
      dout_sum <= '0;
      out_valid <= 1'b0;
      lock_err <= 1'b0;
      seed_ready <= 1'b1;
      fsm <= FSM0;
      wcnt <= '0;
    end else begin
      seed_ready <= !load;
      if (load) begin
        state_q <= seed_bad ? INIT : seed;
        lock_err <= seed_bad;
        dout <= '0;
        dout_sum <= '0;
        out_valid <= 1'b0;
        wcnt <= '0;
        fsm <= FSM0;
      end else if (locked) begin
        state_q <= INIT;
        lock_err <= 1'b1;
        out_valid <= 1'b0;
        wcnt <= '0;
        fsm <= FSM0;
      end else begin
        lock_err <= 1'b0;
        out_valid <= en && (fsm == RUN);
        if (en) begin
          state_q <= nxt;
          dout <= bits;
          dout_sum <= SUM_W'(popcount(64'(bits)));
          if (fsm == WARM) begin
            wcnt <= wcnt + 1'b1;
            if (wcnt == WCW'(WARMUP - 1)) fsm <= RUN;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_lfsr_noise_gen.sv
// tb_lfsr_noise_gen: randomized and directed checks against a behavioural LFSR model
module tb_lfsr_noise_gen;
  localparam logic [14:0] MASK = 15'h6000;
  localparam logic [14:0] INIT = 15'h0001;
  localparam int WU = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  logic en, seed_valid, seed_ready, out_valid, lock_err;
  logic [14:0] seed, state_q;
  logic [1:0] dout, dout_sum;
  logic en1, sv1, sr1, ov1, le1;
  logic [14:0] seed1, st1;
  logic [0:0] dout1, sum1;
  int errors = 0, checks = 0;
  bit ref_bits [0:32766];
  int inj_req = 0, inj_ack = 0;
  lfsr_noise_gen #(.WIDTH(15), .TAP_MASK(MASK), .INIT(INIT), .OUT_BITS(2), .WARMUP(WU)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .seed_valid(seed_valid), .seed(seed),
    .seed_ready(seed_ready), .dout(dout), .dout_sum(dout_sum), .out_valid(out_valid),
    .state_q(state_q), .lock_err(lock_err)
  );
  lfsr_noise_gen #(.WIDTH(15), .TAP_MASK(MASK), .INIT(INIT), .OUT_BITS(1), .WARMUP(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en1), .seed_valid(sv1), .seed(seed1),
    .seed_ready(sr1), .dout(dout1), .dout_sum(sum1), .out_valid(ov1),
    .state_q(st1), .lock_err(le1)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Model: state as a number, warm-up as "enabled cycles since last restart"
  logic [14:0] m_state;
  logic [1:0] m_dout, m_sum;
  logic m_valid, m_lock, m_ready;
  int m_n;
  always @(posedge clk or negedge rst_n) begin
    logic [14:0] s;
    logic fb;
    if (!rst_n) begin
      m_state = INIT; m_dout = 0; m_sum = 0; m_valid = 0; m_lock = 0; m_ready = 1; m_n = 0;
      inj_ack = inj_req;
    end else begin
      s = (inj_req != inj_ack) ? 15'h7fff : m_state;
      inj_ack = inj_req;
      if (seed_valid && m_ready) begin
        m_ready = 0;
        m_lock = (seed == 15'h7fff);
        m_state = m_lock ? INIT : seed;
        m_dout = 0; m_sum = 0; m_valid = 0; m_n = 0;
      end else begin
        m_ready = 1;
        if (s == 15'h7fff) begin
          m_state = INIT; m_lock = 1; m_valid = 0; m_n = 0;
        end else begin
          m_lock = 0;
          m_state = s;
          if (en) begin
            for (int k = 0; k < 2; k++) begin
              fb = ~(^(m_state & MASK));
              m_dout[k] = fb;
              m_state = {m_state[13:0], fb};
            end
            m_sum = 2'(m_dout[0]) + 2'(m_dout[1]);
            m_n++;
            m_valid = (m_n > WU);
          end else m_valid = 0;
        end
      end
    end
  end
  always @(negedge clk) begin
    if (rst_n) begin
      chk("state", 64'(state_q), 64'(m_state));
      chk("dout", 64'(dout), 64'(m_dout));
      chk("dout_sum", 64'(dout_sum), 64'(m_sum));
      chk("out_valid", 64'(out_valid), 64'(m_valid));
      chk("lock_err", 64'(lock_err), 64'(m_lock));
      chk("seed_ready", 64'(seed_ready), 64'(m_ready));
    end
  end
  task automatic upset();
    force dut.state_q = 15'h7fff;
    inj_req++;
    #1;
    release dut.state_q;
  endtask
  task automatic chk_reset_vals(input string name);
    chk({name, "_state"}, 64'(state_q), 64'(INIT));
    chk({name, "_dout"}, 64'(dout), 0);
    chk({name, "_sum"}, 64'(dout_sum), 0);
    chk({name, "_valid"}, 64'(out_valid), 0);
    chk({name, "_lock"}, 64'(lock_err), 0);
    chk({name, "_ready"}, 64'(seed_ready), 1);
  endtask
  initial begin
    int premature;
    en = 0; seed_valid = 0; seed = 0; en1 = 0; sv1 = 0; seed1 = 0;
    #1 rst_n = 0;
    #2 chk_reset_vals("rst");
    chk("rst_st1", 64'(st1), 64'(INIT));
    @(negedge clk); @(negedge clk); #1;
    en1 = 1; rst_n = 1;
    premature = 0;
    for (int i = 1; i <= 32767; i++) begin
      @(negedge clk);
      ref_bits[i-1] = dout1[0];
      if (i == 1) chk("ob1_valid", 64'(ov1), 1);
      if (i <= 13) chk("ob1_seq", 64'(st1), (64'd1 << (i + 1)) - 1);
      if (i == 14) begin
        chk("ob1_step14", 64'(st1), 64'h7ffe);
        chk("ob1_dout14", 64'(dout1), 0);
      end
      if (i < 32767 && st1 == INIT) premature++;
    end
    chk("period", 64'(st1), 64'(INIT));
    chk("early_return", 64'(premature), 0);
    #1 en1 = 0;
    for (int i = 1; i <= 20; i++) begin
      en = 1;
      @(negedge clk);
      chk("warm_valid", 64'(out_valid), 64'(i >= 17));
      chk("ref_pair", 64'(dout), 64'({ref_bits[2*i-1], ref_bits[2*i-2]}));
      chk("ref_sum", 64'(dout_sum), 64'(ref_bits[2*i-1]) + 64'(ref_bits[2*i-2]));
      #1;
    end
    seed_valid = 1; seed = 15'h1234; en = 1;
    @(negedge clk);
    chk("seed_state", 64'(state_q), 64'h1234);
    chk("seed_valid_lo", 64'(out_valid), 0);
    chk("seed_ready_lo", 64'(seed_ready), 0);
    #1 seed_valid = 0;
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      chk("seed_warm", 64'(out_valid), 64'(i >= 17));
      #1;
    end
    en = 0; seed_valid = 1; seed = 15'h7fff;
    @(negedge clk);
    chk("bad_seed_state", 64'(state_q), 64'(INIT));
    chk("bad_seed_lock", 64'(lock_err), 1);
    chk("bad_seed_ready", 64'(seed_ready), 0);
    #1 seed_valid = 0;
    @(negedge clk);
    chk("bad_seed_lock_off", 64'(lock_err), 0);
    chk("bad_seed_ready_on", 64'(seed_ready), 1);
    #1 en = 1;
    for (int i = 0; i < 20; i++) begin @(negedge clk); #1; end
    upset();
    @(negedge clk);
    chk("upset_state", 64'(state_q), 64'(INIT));
    chk("upset_lock", 64'(lock_err), 1);
    chk("upset_valid", 64'(out_valid), 0);
    #1;
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      if (i == 1) chk("upset_lock_off", 64'(lock_err), 0);
      chk("upset_warm", 64'(out_valid), 64'(i >= 17));
      #1;
    end
    for (int i = 0; i < 800; i++) begin
      if (i == 400) begin
        rst_n = 0;
        #1 chk_reset_vals("async_rst");
        @(negedge clk); #1;
        rst_n = 1;
      end
      en = ($urandom_range(0, 9) < 7);
      seed_valid = ($urandom_range(0, 15) == 0);
      seed = ($urandom_range(0, 3) == 0) ? 15'h7fff : 15'($urandom);
      if ($urandom_range(0, 63) == 0) upset();
      @(negedge clk); #1;
    end
    en = 0; seed_valid = 0;
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
